data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 107 ++++++++++
 tb/tb_data_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit bridging CPU memory ops onto a word-only backend
module data_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100, SH = 6'b101000, SB = 6'b101001;
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;
    state_t state;
    logic [5:0] op_q;
    logic [31:0] a_q, wbuf, load_v, merged;
    logic [CW-1:0] cnt;
    logic [1:0] sz_in, sz_q;
    logic mis_in, sgn;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    // size code: 0 byte, 1 halfword, 2 word (anything unlisted is a word)
    function automatic logic [1:0] size_of(input logic [5:0] op);
        return (op == LB || op == LBU || op == SB) ? 2'd0 : (op == LH || op == LHU || op == SH) ? 2'd1 : 2'd2;
    endfunction

    assign sz_in = size_of(opcode);
    assign sz_q = size_of(op_q);
    assign mis_in = (sz_in == 2'd2) ? |addr[1:0] : ((sz_in == 2'd1) & addr[0]);
    assign stall = (read_mem | write_mem) & (state != DONE);
    assign mem_req = state inside {RD, WR, RMW_RD, RMW_WR};
    assign mem_we = (state == WR) || (state == RMW_WR);
    assign mem_addr = a_q[31:2];
    assign mem_wdata = wbuf;

    // lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_v = mem_rdata[{a_q[1:0], 3'b000} +: 8];
        half_v = mem_rdata[{a_q[1], 4'b0000} +: 16];
        sgn = (op_q == LB) || (op_q == LH);
        load_v = (sz_q == 2'd0) ? {{24{sgn & byte_v[7]}}, byte_v} : (sz_q == 2'd1) ? {{16{sgn & half_v[15]}}, half_v} : mem_rdata;
        merged = mem_rdata;
        if (sz_q == 2'd0)
            merged[{a_q[1:0], 3'b000} +: 8] = wbuf[7:0];
        else
            merged[{a_q[1], 4'b0000} +: 16] = wbuf[15:0];
    end

    // access FSM: capture request in IDLE, run one or two backend transactions, pulse results in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            a_q <= '0;
            wbuf <= '0;
            cnt <= '0;
            rdata <= '0;
            misaligned <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (read_mem | write_mem) begin
                    op_q <= opcode;
                    a_q <= addr;
                    wbuf <= wdata;
                    rdata <= '0;
                    cnt <= '0;
                    if (read_mem && write_mem) begin
                        bus_err <= 1'b1;
                        state <= DONE;
                    end else if (mis_in) begin
                        misaligned <= 1'b1;
                        state <= DONE;
                    end else
                        state <= read_mem ? RD : (sz_in == 2'd2) ? WR : RMW_RD;
                end
                RD, WR, RMW_RD, RMW_WR: if (mem_ack) begin
                    cnt <= '0;
                    if (state == RD) rdata <= load_v;
                    if (state == RMW_RD) wbuf <= merged;
                    state <= (state == RMW_RD) ? RMW_WR : DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    bus_err <= 1'b1;
                    state <= DONE;
                end else
                    cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: random and directed load/store traffic against a reference memory model
module tb_data_mem_ctrl;
    localparam int TO = 4;
    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100, SW = 6'b101011, SH = 6'b101000, SB = 6'b101001;

    typedef struct {logic [31:0] rdata; bit ld; bit mis; bit berr;} res_t;
    typedef struct {bit we; logic [29:0] a; logic [31:0] d;} bus_t;

    logic clk = 0, rst = 1, read_mem = 0, write_mem = 0, mem_ack = 0;
    logic [5:0] opcode = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic [31:0] rdata, mem_wdata;
    logic stall, misaligned, bus_err, mem_req, mem_we;
    logic [29:0] mem_addr;

    int total = 0, bad = 0;
    logic [31:0] bmem[int];
    logic [31:0] rmem[int];
    res_t exp_res[$];
    bus_t exp_bus[$];
    bit no_ack = 0, no_ack_wr = 0;
    int fixed_dly = -1, req_cycles = 0;
    logic [5:0] ops[9] = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'b000111};

    data_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .read_mem(read_mem), .write_mem(write_mem), .opcode(opcode),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference model: byte-addressed arithmetic on a word array
    task automatic model(input logic [5:0] op, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int sz = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
        bit sg = (op == LB || op == LH);
        int wa = int'(a >> 2);
        int sh = 8 * int'(a % 4);
        longint mask = (64'd1 << (8 * sz)) - 1;
        longint v, x, nv;
        res_t er = '{rdata: 32'd0, ld: r, mis: 1'b0, berr: 1'b0};
        if (r && w) begin
            er.berr = 1;
            er.ld = 0;
        end else if (a % sz != 0)
            er.mis = 1;
        else begin
            v = rmem.exists(wa) ? longint'(rmem[wa]) : 0;
            if (r) begin
                x = (v >> sh) & mask;
                if (sg && x > mask / 2) x -= mask + 1;
                er.rdata = 32'(x);
                exp_bus.push_back('{we: 1'b0, a: 30'(wa), d: 32'd0});
            end else if (sz == 4) begin
                rmem[wa] = d;
                exp_bus.push_back('{we: 1'b1, a: 30'(wa), d: d});
            end else begin
                nv = (v & ~(mask << sh)) | ((longint'(d) & mask) << sh);
                rmem[wa] = 32'(nv);
                exp_bus.push_back('{we: 1'b0, a: 30'(wa), d: 32'd0});
                exp_bus.push_back('{we: 1'b1, a: 30'(wa), d: 32'(nv)});
            end
        end
        exp_res.push_back(er);
    endtask

    // issue one access at posedge+1, wait for the DONE cycle, then drop the request
    task automatic run(input logic [5:0] op, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit to, output int n);
        if (to) exp_res.push_back('{rdata: 32'd0, ld: 1'b0, mis: 1'b0, berr: 1'b1});
        else model(op, r, w, a, d);
        opcode = op;
        addr = a;
        wdata = d;
        read_mem = r;
        write_mem = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 300);
        if (stall) begin
            total++;
            bad++;
            $display("FAIL run_wait: stall=%0b after %0d cycles, required 0", stall, n);
        end
        @(posedge clk);
        #1;
        read_mem = 0;
        write_mem = 0;
    endtask

    // backend: random ack latency, word memory, checks each acked transaction
    initial begin
        bit busy;
        int dly;
        bus_t e;
        busy = 0;
        dly = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 0;
                busy = 0;
            end
            if (!mem_req) busy = 0;
            else begin
                req_cycles++;
                if (!busy) begin
                    busy = 1;
                    dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
                end
                if (!(no_ack || (no_ack_wr && mem_we))) begin
                    if (dly == 0) begin
                        mem_ack = 1;
                        if (exp_bus.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL bus_extra: transaction we=%0b addr=%h, required none", mem_we, mem_addr);
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_we", 32'(mem_we), 32'(e.we));
                            chk("bus_addr", 32'(mem_addr), 32'(e.a));
                            if (e.we) chk("bus_wdata", mem_wdata, e.d);
                        end
                        if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
                        else mem_rdata = bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : 32'd0;
                    end else
                        dly--;
                end
            end
        end
    end

    // result monitor: the DONE cycle is the one where a request is held but stall is low
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && (read_mem || write_mem) && !stall) begin
                if (exp_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_extra: unexpected completion, required none");
                end else begin
                    e = exp_res.pop_front();
                    chk("misaligned", 32'(misaligned), 32'(e.mis));
                    chk("bus_err", 32'(bus_err), 32'(e.berr));
                    if (e.ld || e.mis) chk("rdata", rdata, e.rdata);
                end
            end else if (!rst && stall)
                chk("pulse_outside_done", 32'({misaligned, bus_err}), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bit r, w;
        for (int i = 0; i < 256; i++) begin
            rmem[i] = $urandom;
            bmem[i] = rmem[i];
        end
        rmem['h400] = 32'h80FF_0000;
        bmem['h400] = 32'h80FF_0000;
        rmem['h800] = 32'h1122_3344;
        bmem['h800] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_pulses", 32'({misaligned, bus_err}), 0);
        rst = 0;
        @(posedge clk);
        #1;
        run(LB, 1, 0, 32'h1003, 0, 0, n);
        chk("lb_signext", rdata, 32'hFFFF_FF80);
        run(LBU, 1, 0, 32'h1003, 0, 0, n);
        chk("lbu_zeroext", rdata, 32'h0000_0080);
        fixed_dly = 2;
        run(SH, 0, 1, 32'h2002, 32'h0000_BEEF, 0, n);
        fixed_dly = -1;
        chk("sh_cycles", 32'(n), 8);
        chk("sh_mem", bmem['h800], 32'hBEEF_3344);
        run(LW, 1, 0, 32'h0000_0006, 0, 0, n);
        chk("lw_mis_cycles", 32'(n), 2);
        chk("lw_mis_rdata", rdata, 0);
        no_ack = 1;
        req_cycles = 0;
        run(SW, 0, 1, 32'h40, 32'hDEAD_BEEF, 1, n);
        no_ack = 0;
        chk("timeout_req_cycles", 32'(req_cycles), TO);
        run(LW, 1, 1, 32'h10, 0, 0, n);
        // reset in the write half of a read-modify-write
        no_ack_wr = 1;
        exp_bus.push_back('{we: 1'b0, a: 30'h800, d: 32'd0});
        opcode = SB;
        addr = 32'h2001;
        wdata = 32'h55;
        write_mem = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_we) && n < 100);
        chk("rmw_wr_reached", 32'(mem_req && mem_we), 1);
        #2;
        rst = 1;
        #1;
        chk("rst_async_req", 32'(mem_req), 0);
        chk("rst_async_we", 32'(mem_we), 0);
        @(negedge clk);
        write_mem = 0;
        chk("rst_mid_rdata", rdata, 0);
        @(negedge clk);
        rst = 0;
        no_ack_wr = 0;
        req_cycles = 0;
        repeat (5) @(negedge clk);
        chk("post_rst_req", 32'(req_cycles), 0);
        chk("rst_no_write", bmem['h800], 32'hBEEF_3344);
        @(posedge clk);
        #1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 8);
            r = (k < 5) || (k == 8 && $urandom_range(0, 1) == 1);
            w = !r;
            if ($urandom_range(0, 15) == 0) begin
                r = 1;
                w = 1;
            end
            run(ops[k], r, w, $urandom_range(0, 1023), $urandom, 0, n);
        end
        repeat (5) @(negedge clk);
        chk("res_queue_empty", 32'(exp_res.size()), 0);
        chk("bus_queue_empty", 32'(exp_bus.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
